mem_io_fabric: RTL and testbench
================================

// Module: mem_io_fabric
// PURPOSE
//  Parametrised data-bus fabric between CPU data port and D-RAM, I/O peripherals and VRAM.
//  Decodes address into regions, issues single-cycle strobes, inserts per-region wait states,
//  OR-combines N_SLOTS peripheral read buses, registers read data, flags unmapped/illegal access.
//  Successor to the fixed combinational RAM/IO decoder; adds ready handshake, wait states, bus error.
// PARAMETERS
//  N_SLOTS       8        number of I/O peripheral read-data channels OR-combined
//  DRAM_BASE     16'h0000 D-RAM base; region size 2**DRAM_AW bytes
//  DRAM_AW       11       D-RAM address width
//  IO_BASE       16'h1000 I/O base; region size 2**IO_AW bytes
//  IO_AW         8        I/O address width
//  VRAM_BASE     16'h2000 VRAM first address (write-only region)
//  VRAM_TOP      16'h2960 VRAM last address, inclusive
//  DRAM_WAIT     0        extra wait cycles for D-RAM access (0..15)
//  IO_WAIT       1        extra wait cycles for I/O access (0..15)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           asynchronous, active-low reset
//  address      in   16          CPU address, held stable until ready
//  din          in   8           CPU write data, held stable until ready
//  w_en         in   1           CPU write request, held until ready
//  r_en         in   1           CPU read request, held until ready
//  dout         out  8           registered read data, valid while ready=1
//  ready        out  1           one-cycle access-complete pulse
//  bus_err      out  1           sticky error flag
//  err_addr     out  16          address of first error since last clear
//  err_clr      in   1           clears bus_err and err_addr
//  dram_w_en    out  1           D-RAM write strobe
//  dram_r_en    out  1           D-RAM read enable
//  dram_dout    in   8           D-RAM read data
//  io_w_en      out  1           I/O write strobe (peripherals decode address[IO_AW-1:0])
//  io_r_en      out  1           I/O read enable
//  io_dout      in   8*N_SLOTS   peripheral read buses, slot k at [8k+7:8k]
//  vram_w_en    out  1           VRAM write strobe
// BEHAVIOUR
//  Reset: FSM=IDLE; dout=0, ready=0, bus_err=0, err_addr=0, all strobes/enables 0.
//  Decode: region hit iff address within [BASE, BASE+2**AW-1] (VRAM: [VRAM_BASE,VRAM_TOP]).
//   Regions must not overlap (checked by bench, not RTL). Other addresses are unmapped.
//  FSM IDLE/WAIT/ACK:
//   IDLE: on (w_en|r_en) latch region, load cnt=region WAIT; cnt=0 -> ACK else -> WAIT.
//   WAIT: cnt decrements each cycle; cnt==1 -> ACK.
//   ACK: ready=1 for exactly one cycle -> IDLE. CPU drops request in the ACK cycle.
//  Write strobes (dram_w_en/io_w_en/vram_w_en) high ONLY in the first cycle after IDLE
//   accepts; never repeated across wait cycles.
//  Read enables (dram_r_en/io_r_en) high from accept through the cycle before ACK.
//  Read data: dout <= dram_dout or OR-reduction of all io_dout slots, sampled on the
//   clock entering ACK. Latency request->ready = WAIT+1 cycles (min 1).
//  Reads of VRAM or unmapped: dout=0, no enables, bus_err set, ACK still given.
//  Writes to unmapped: no strobes, bus_err set, ACK still given.
//  w_en & r_en both high: illegal; no strobes, dout=0, bus_err set, ACK given.
//  err_addr captured only when bus_err is 0 (first error kept).
//  err_clr and new error same cycle: new error wins (bus_err=1, err_addr=new).
//  Request still high in the cycle after ACK starts a new access (back-to-back allowed).
//  Async reset mid-access: access aborted, no strobe, no ready.
//  dout holds last value between accesses.
// TESTING
//  DRAM_WAIT=0: write 0xA5 @0x0010, read back -> dram_w_en 1 cycle, ready after 1, dout=0xA5.
//  IO_WAIT=3: read @0x1009, slot2=0x3C others 0 -> io_r_en 3 cycles, ready cycle 4, dout=0x3C.
//  Write @0x2960 then @0x2961 -> vram_w_en once; second: bus_err=1, err_addr=0x2961.
//  Unmapped write @0x0800, then @0x3000 -> err_addr stays 0x0800; err_clr -> bus_err=0, err_addr=0.
//  err_clr same cycle as error @0x5000 -> bus_err=1, err_addr=0x5000.
//  rst low during IO_WAIT=3 write after strobe -> ready never pulses; all outputs at reset values.

Source files
------------

// File: rtl/mem_io_fabric.sv
// mem_io_fabric: CPU data-bus fabric in front of D-RAM, I/O peripherals and VRAM.
// Decodes the CPU address into a region, issues one-shot write strobes and held read
// enables, inserts per-region wait states, registers read data, and keeps a sticky
// bus-error flag with the address of the first failing access.
module mem_io_fabric #(
  parameter int          N_SLOTS   = 8,
  parameter logic [15:0] DRAM_BASE = 16'h0000,
  parameter int          DRAM_AW   = 11,
  parameter logic [15:0] IO_BASE   = 16'h1000,
  parameter int          IO_AW     = 8,
  parameter logic [15:0] VRAM_BASE = 16'h2000,
  parameter logic [15:0] VRAM_TOP  = 16'h2960,
  parameter int          DRAM_WAIT = 0,
  parameter int          IO_WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          address,
  input  logic [7:0]           din,
  input  logic                 w_en,
  input  logic                 r_en,
  output logic [7:0]           dout,
  output logic                 ready,
  output logic                 bus_err,
  output logic [15:0]          err_addr,
  input  logic                 err_clr,
  output logic                 dram_w_en,
  output logic                 dram_r_en,
  input  logic [7:0]           dram_dout,
  output logic                 io_w_en,
  output logic                 io_r_en,
  input  logic [8*N_SLOTS-1:0] io_dout,
  output logic                 vram_w_en
);

  // state  | meaning
  // S_IDLE | waiting for a CPU request
  // S_WAIT | counting down region wait states
  // S_ACK  | ready pulse, access complete
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_DRAM = 2'd1;
  localparam logic [1:0] R_IO   = 2'd2;
  localparam logic [1:0] R_VRAM = 2'd3;

  localparam logic [3:0]  DRAM_WAIT_C = 4'(DRAM_WAIT);
  localparam logic [3:0]  IO_WAIT_C   = 4'(IO_WAIT);
  localparam logic [16:0] VRAM_SPAN   = {1'b0, VRAM_TOP} - {1'b0, VRAM_BASE};

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  region_q;
  logic        rd_q;
  logic [16:0] dram_off, io_off, vram_off;
  logic        hit_dram, hit_io, hit_vram;
  logic        req, wr_ok, rd_ok, acc_err, accept, to_ack;
  logic [3:0]  acc_wait;
  logic [1:0]  acc_region;
  logic [7:0]  io_rdata;
  logic        unused_din;

  // Write data goes straight from the CPU to the memories; the fabric never looks at it.
  assign unused_din = ^din;

  // Region decode: offsets below a base wrap into bit 16 and so never hit
  always_comb begin
    dram_off = {1'b0, address} - {1'b0, DRAM_BASE};
    io_off   = {1'b0, address} - {1'b0, IO_BASE};
    vram_off = {1'b0, address} - {1'b0, VRAM_BASE};
    hit_dram = (dram_off >> DRAM_AW) == 17'd0;
    hit_io   = (io_off >> IO_AW) == 17'd0;
    hit_vram = vram_off <= VRAM_SPAN;
  end

  // Classify the pending request and pick its wait count; errors complete with no waits
  always_comb begin
    req        = w_en | r_en;
    wr_ok      = w_en & ~r_en & (hit_dram | hit_io | hit_vram);
    rd_ok      = r_en & ~w_en & (hit_dram | hit_io);
    acc_err    = req & ~wr_ok & ~rd_ok;
    accept     = (state == S_IDLE) & req;
    acc_region = R_NONE;
    acc_wait   = 4'd0;
    if (!acc_err) begin
      if (hit_dram) begin
        acc_region = R_DRAM;
        acc_wait   = DRAM_WAIT_C;
      end else if (hit_io) begin
        acc_region = R_IO;
        acc_wait   = IO_WAIT_C;
      end else if (hit_vram) begin
        acc_region = R_VRAM;
      end
    end
    to_ack = (accept & (acc_wait == 4'd0)) | ((state == S_WAIT) & (cnt == 4'd1));
  end

  // Read enables: on a zero-wait access they must be up in the accept cycle itself,
  // otherwise they cover the wait cycles and the data is taken on the edge into ACK
  always_comb begin
    dram_r_en = (accept & rd_ok & (acc_region == R_DRAM) & (acc_wait == 4'd0)) |
                ((state == S_WAIT) & rd_q & (region_q == R_DRAM));
    io_r_en   = (accept & rd_ok & (acc_region == R_IO) & (acc_wait == 4'd0)) |
                ((state == S_WAIT) & rd_q & (region_q == R_IO));
  end

  // OR-combine the peripheral read buses; idle peripherals drive zero
  always_comb begin
    io_rdata = 8'h00;
    for (int k = 0; k < N_SLOTS; k++) io_rdata = io_rdata | io_dout[8*k +: 8];
  end

  // Access sequencer with wait-state down-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      region_q <= R_NONE;
      rd_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          region_q <= acc_region;
          rd_q     <= rd_ok;
          cnt      <= acc_wait;
          state    <= (acc_wait == 4'd0) ? S_ACK : S_WAIT;
        end
        S_WAIT: if (cnt == 4'd1) state <= S_ACK;
                else cnt <= cnt - 4'd1;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_ACK);

  // Write strobes: a single cycle right after accept, never repeated during waits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dram_w_en <= 1'b0;
      io_w_en   <= 1'b0;
      vram_w_en <= 1'b0;
    end else begin
      dram_w_en <= accept & wr_ok & (acc_region == R_DRAM);
      io_w_en   <= accept & wr_ok & (acc_region == R_IO);
      vram_w_en <= accept & wr_ok & (acc_region == R_VRAM);
    end
  end

  // Read data register: loaded on the edge into ACK, holds between accesses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 8'h00;
    end else if (to_ack) begin
      if (dram_r_en)                 dout <= dram_dout;
      else if (io_r_en)              dout <= io_rdata;
      else if (accept & r_en & acc_err) dout <= 8'h00;
    end
  end

  // Sticky error: keeps the first address; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err  <= 1'b0;
      err_addr <= 16'h0000;
    end else if (accept & acc_err) begin
      bus_err <= 1'b1;
      if (!bus_err || err_clr) err_addr <= address;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_addr <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_mem_io_fabric.sv
// Bench for mem_io_fabric: directed accesses, a cycle-level expectation model derived
// from the access rules, and a negedge compare process checking every output each cycle.
module tb_mem_io_fabric;

  localparam int DRAM_WAIT_TB = 0;
  localparam int IO_WAIT_TB   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [7:0]  dout, dram_dout;
  logic        ready, bus_err, dram_w_en, dram_r_en, io_w_en, io_r_en, vram_w_en;
  logic [15:0] err_addr;
  logic [63:0] io_dout;

  logic [7:0] slot [8];
  logic [7:0] stub [2048];
  logic [7:0] model_mem [2048];

  assign io_dout   = {slot[7], slot[6], slot[5], slot[4], slot[3], slot[2], slot[1], slot[0]};
  assign dram_dout = stub[address[10:0]];

  mem_io_fabric #(
    .N_SLOTS(8), .DRAM_BASE(16'h0000), .DRAM_AW(11), .IO_BASE(16'h1000), .IO_AW(8),
    .VRAM_BASE(16'h2000), .VRAM_TOP(16'h2960), .DRAM_WAIT(DRAM_WAIT_TB), .IO_WAIT(IO_WAIT_TB)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .din(din), .w_en(w_en), .r_en(r_en),
    .dout(dout), .ready(ready), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr),
    .dram_w_en(dram_w_en), .dram_r_en(dram_r_en), .dram_dout(dram_dout),
    .io_w_en(io_w_en), .io_r_en(io_r_en), .io_dout(io_dout), .vram_w_en(vram_w_en)
  );

  always #5 clk = ~clk;

  // D-RAM stub: written by the fabric's strobe with the CPU's held address and data
  always @(posedge clk) if (dram_w_en) stub[address[10:0]] <= din;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, req_cyc = 0, last_ready_cyc = 0;
  int cnt_io_r = 0, cnt_ready = 0, cnt_vram = 0, cnt_dram_w = 0;

  logic [7:0]  exp_dout = 8'h00;
  logic        exp_ready = 1'b0, exp_bus_err = 1'b0;
  logic [15:0] exp_err_addr = 16'h0000;
  logic        exp_dram_w = 1'b0, exp_dram_r = 1'b0, exp_io_w = 1'b0, exp_io_r = 1'b0;
  logic        exp_vram_w = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Compare every output against the model each cycle, away from the clock edge
  always @(negedge clk) begin
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
    chk("err_addr", 32'(err_addr), 32'(exp_err_addr));
    chk("dram_w_en", 32'(dram_w_en), 32'(exp_dram_w));
    chk("dram_r_en", 32'(dram_r_en), 32'(exp_dram_r));
    chk("io_w_en", 32'(io_w_en), 32'(exp_io_w));
    chk("io_r_en", 32'(io_r_en), 32'(exp_io_r));
    chk("vram_w_en", 32'(vram_w_en), 32'(exp_vram_w));
    if (ready) begin
      last_ready_cyc = cyc;
      cnt_ready++;
    end
    if (io_r_en) cnt_io_r++;
    if (vram_w_en) cnt_vram++;
    if (dram_w_en) cnt_dram_w++;
    cyc++;
  end

  function automatic logic in_dram(input logic [15:0] a);
    return int'(a) >= 32'h0000 && int'(a) <= 32'h07FF;
  endfunction
  function automatic logic in_io(input logic [15:0] a);
    return int'(a) >= 32'h1000 && int'(a) <= 32'h10FF;
  endfunction
  function automatic logic in_vram(input logic [15:0] a);
    return int'(a) >= 32'h2000 && int'(a) <= 32'h2960;
  endfunction
  function automatic logic [7:0] io_or_model();
    logic [7:0] v = 8'h00;
    for (int k = 0; k < 8; k++) v = v | slot[k];
    return v;
  endfunction

  // One CPU access, entered at posedge+1 of the request cycle; returns at posedge+1
  // of the cycle after ready, with the expectations for every cycle in between set.
  task automatic access(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic r, input logic clr);
    logic id, ii, iv, ok_wr, ok_rd, err;
    int nw;
    logic [7:0] nd;
    id = in_dram(a); ii = in_io(a); iv = in_vram(a);
    ok_wr = w && !r && (id || ii || iv);
    ok_rd = r && !w && (id || ii);
    err   = !(ok_wr || ok_rd);
    nw    = err ? 0 : id ? DRAM_WAIT_TB : ii ? IO_WAIT_TB : 0;
    if (ok_rd)  nd = id ? model_mem[a[10:0]] : io_or_model();
    else if (r) nd = 8'h00;
    else        nd = exp_dout;
    address = a; din = d; w_en = w; r_en = r; err_clr = clr;
    req_cyc = cyc;
    exp_ready = 1'b0; exp_dram_w = 1'b0; exp_io_w = 1'b0; exp_vram_w = 1'b0;
    exp_dram_r = ok_rd && id && (nw == 0);
    exp_io_r   = ok_rd && ii && (nw == 0);
    for (int c = 1; c <= nw + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        err_clr = 1'b0;
        if (err) begin
          if (!exp_bus_err || clr) exp_err_addr = a;
          exp_bus_err = 1'b1;
        end else if (clr) begin
          exp_bus_err = 1'b0;
          exp_err_addr = 16'h0000;
        end
        if (ok_wr && id) model_mem[a[10:0]] = d;
      end
      exp_dram_w = (c == 1) && ok_wr && id;
      exp_io_w   = (c == 1) && ok_wr && ii;
      exp_vram_w = (c == 1) && ok_wr && iv;
      exp_dram_r = ok_rd && id && (c <= nw);
      exp_io_r   = ok_rd && ii && (c <= nw);
      exp_ready  = (c == nw + 1);
      if (c == nw + 1) begin
        exp_dout = nd;
        w_en = 1'b0;
        r_en = 1'b0;
      end
    end
    @(posedge clk); #1;
    exp_ready = 1'b0; exp_dram_w = 1'b0; exp_io_w = 1'b0; exp_vram_w = 1'b0;
    exp_dram_r = 1'b0; exp_io_r = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_bus_err = 1'b0;
    exp_err_addr = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      stub[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    for (int k = 0; k < 8; k++) slot[k] = 8'h00;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_err_addr", 32'(err_addr), 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // D-RAM write then read back, zero wait states
    cnt_dram_w = 0;
    access(16'h0010, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("dram_w_once", 32'(cnt_dram_w), 32'd1);
    access(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("dram_rd_data", 32'(dout), 32'h A5);
    chk("dram_rd_latency", 32'(last_ready_cyc - req_cyc), 32'd1);

    // I/O read with three wait states, single slot driving
    slot[2] = 8'h3C;
    cnt_io_r = 0;
    access(16'h1009, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("io_r_en_cycles", 32'(cnt_io_r), 32'd3);
    chk("io_rd_data", 32'(dout), 32'h3C);
    chk("io_rd_latency", 32'(last_ready_cyc - req_cyc), 32'd4);

    // Several slots OR-combined, region bottom and top edges
    slot[0] = 8'h01; slot[5] = 8'h80;
    access(16'h1000, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("io_or_data", 32'(dout), 32'hBD);
    access(16'h10FF, 8'h42, 1'b1, 1'b0, 1'b0);
    access(16'h07FF, 8'h5A, 1'b1, 1'b0, 1'b0);
    access(16'h07FF, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("dram_top_data", 32'(dout), 32'h5A);

    // VRAM last address then one past it
    cnt_vram = 0;
    access(16'h2960, 8'h11, 1'b1, 1'b0, 1'b0);
    access(16'h2961, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("vram_w_once", 32'(cnt_vram), 32'd1);
    chk("vram_past_err", 32'(bus_err), 32'd1);
    chk("vram_past_addr", 32'(err_addr), 32'h2961);
    clear_err();

    // First error kept, then cleared
    access(16'h0800, 8'h33, 1'b1, 1'b0, 1'b0);
    access(16'h3000, 8'h44, 1'b1, 1'b0, 1'b0);
    chk("first_err_kept", 32'(err_addr), 32'h0800);
    clear_err();
    chk("clr_bus_err", 32'(bus_err), 32'd0);
    chk("clr_err_addr", 32'(err_addr), 32'h0);

    // Clear and a new error in the same cycle: the new one wins
    access(16'h3000, 8'h44, 1'b1, 1'b0, 1'b0);
    access(16'h5000, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("clr_vs_err_flag", 32'(bus_err), 32'd1);
    chk("clr_vs_err_addr", 32'(err_addr), 32'h5000);
    clear_err();

    // VRAM read returns zero and errors
    access(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0);
    access(16'h2000, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("vram_rd_zero", 32'(dout), 32'h0);
    chk("vram_rd_addr", 32'(err_addr), 32'h2000);
    clear_err();

    // Simultaneous read and write request is illegal
    cnt_dram_w = 0;
    access(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0);
    access(16'h0010, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("illegal_no_strobe", 32'(cnt_dram_w), 32'd0);
    chk("illegal_dout", 32'(dout), 32'h0);
    clear_err();

    // Read just past the I/O window
    access(16'h1100, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("io_past_addr", 32'(err_addr), 32'h1100);
    access(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of a waited I/O write, after its strobe
    cnt_ready = 0;
    address = 16'h1005; din = 8'h77; w_en = 1'b1;
    @(posedge clk); #1;
    exp_io_w = 1'b1;
    @(posedge clk); #1;
    exp_io_w = 1'b0;
    #2;
    rst = 1'b0; w_en = 1'b0;
    exp_dout = 8'h00; exp_bus_err = 1'b0; exp_err_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_dout", 32'(dout), 32'h0);
    chk("rst_mid_io_w", 32'(io_w_en), 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_ready", 32'(cnt_ready), 32'd0);

    // Normal operation resumes after reset
    access(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_rd", 32'(dout), 32'hA5);
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
